// File: rtl/schmitt_pkg.sv
// Shared types and helpers for the multi-channel Schmitt trigger / debouncer.
// Optional build macro: SCHMITT_TRIGGER_SYNC_EN (adds a 2-flop input synchroniser in the top).
package schmitt_pkg;

   // Per-channel filter state. START holds until the first enabled sample,
   // which fixes the initial level without producing an edge event.
   typedef enum logic [2:0] {
      START = 3'd0,
      LOW   = 3'd1,
      RISE  = 3'd2,
      HIGH  = 3'd3,
      FALL  = 3'd4
   } schmitt_state_t;

   // Counter width able to hold max(rise, fall); never narrower than 1 bit.
   function automatic int calc_cnt_width(input int rise, input int fall);
      int m;
      int w;
      m = (rise > fall) ? rise : fall;
      w = $clog2(m + 1);
      if (w < 1) w = 1;
      return w;
   endfunction

endpackage

// File: rtl/schmitt_channel.sv
// One debounce channel: state machine, run-length counter and registered
// rise/fall event pulses. State is exposed on o_state for observation.
module schmitt_channel
   import schmitt_pkg::*;
#(
   parameter int p_rise_scale = 5,
   parameter int p_fall_scale = 5
) (
   input  logic           i_clk,
   input  logic           i_rst_n,
   input  logic           i_en,
   input  logic           i_in,
   output logic           o_out,
   output logic           o_rise,
   output logic           o_fall,
   output schmitt_state_t o_state
);

   localparam int CW = calc_cnt_width(p_rise_scale, p_fall_scale);
   localparam logic [CW-1:0] RISE_LAST = CW'(p_rise_scale - 1);
   localparam logic [CW-1:0] FALL_LAST = CW'(p_fall_scale - 1);
   localparam logic [CW-1:0] CNT_ONE   = CW'(1);

   schmitt_state_t  state_q, state_d;
   logic [CW-1:0]   cnt_q, cnt_d;
   logic            rise_q, rise_d;
   logic            fall_q, fall_d;

   // State register, counter and event pulse registers.
   always_ff @(posedge i_clk or negedge i_rst_n) begin
      if (!i_rst_n) begin
         state_q <= START;
         cnt_q   <= '0;
         rise_q  <= 1'b0;
         fall_q  <= 1'b0;
      end else begin
         state_q <= state_d;
         cnt_q   <= cnt_d;
         rise_q  <= rise_d;
         fall_q  <= fall_d;
      end
   end

   // Next state: count consecutive opposite samples; an interrupted run
   // returns to the settled state silently (glitch rejected).
   always_comb begin
      state_d = state_q;
      cnt_d   = cnt_q;
      rise_d  = 1'b0;
      fall_d  = 1'b0;
      if (i_en) begin
         case (state_q)
            START: begin
               cnt_d   = '0;
               state_d = i_in ? HIGH : LOW;
            end
            LOW: begin
               if (!i_in) begin
                  cnt_d = '0;
               end else if (p_rise_scale == 1) begin
                  state_d = HIGH;
                  cnt_d   = '0;
                  rise_d  = 1'b1;
               end else begin
                  state_d = RISE;
                  cnt_d   = CNT_ONE;
               end
            end
            RISE: begin
               if (!i_in) begin
                  state_d = LOW;
                  cnt_d   = '0;
               end else if (cnt_q == RISE_LAST) begin
                  state_d = HIGH;
                  cnt_d   = '0;
                  rise_d  = 1'b1;
               end else begin
                  cnt_d = cnt_q + CNT_ONE;
               end
            end
            HIGH: begin
               if (i_in) begin
                  cnt_d = '0;
               end else if (p_fall_scale == 1) begin
                  state_d = LOW;
                  cnt_d   = '0;
                  fall_d  = 1'b1;
               end else begin
                  state_d = FALL;
                  cnt_d   = CNT_ONE;
               end
            end
            FALL: begin
               if (i_in) begin
                  state_d = HIGH;
                  cnt_d   = '0;
               end else if (cnt_q == FALL_LAST) begin
                  state_d = LOW;
                  cnt_d   = '0;
                  fall_d  = 1'b1;
               end else begin
                  cnt_d = cnt_q + CNT_ONE;
               end
            end
            default: begin
               state_d = START;
               cnt_d   = '0;
            end
         endcase
      end
   end

   // Outputs decoded from registered state; level is high while settled
   // high or while a fall is still being qualified.
   always_comb begin
      o_out   = 1'b0;
      o_state = state_q;
      o_rise  = rise_q;
      o_fall  = fall_q;
      if (state_q == HIGH || state_q == FALL) o_out = 1'b1;
   end

endmodule

// File: rtl/schmitt_trigger_array.sv
// Array of independent debounce channels with optional input synchroniser.
// Optional build macro: SCHMITT_TRIGGER_SYNC_EN -- when defined every input
// bit passes through two reset-to-0 flops (free-running, ignores i_en).
module schmitt_trigger_array
   import schmitt_pkg::*;
#(
   parameter int p_channels   = 8,
   parameter int p_rise_scale = 5,
   parameter int p_fall_scale = 5
) (
   input  logic                  i_clk,
   input  logic                  i_rst_n,
   input  logic                  i_en,
   input  logic [p_channels-1:0] i_in,
   output logic [p_channels-1:0] o_out,
   output logic [p_channels-1:0] o_rise,
   output logic [p_channels-1:0] o_fall,
   output logic                  o_busy
);

   logic [p_channels-1:0] in_s;
   schmitt_state_t        state_w [p_channels];

`ifdef SCHMITT_TRIGGER_SYNC_EN
   logic [p_channels-1:0] sync1_q, sync2_q;

   // Two-stage synchroniser for asynchronous pins.
   always_ff @(posedge i_clk or negedge i_rst_n) begin
      if (!i_rst_n) begin
         sync1_q <= '0;
         sync2_q <= '0;
      end else begin
         sync1_q <= i_in;
         sync2_q <= sync1_q;
      end
   end

   assign in_s = sync2_q;
`else
   assign in_s = i_in;
`endif

   genvar k;
   generate
      for (k = 0; k < p_channels; k++) begin : g_ch
         schmitt_channel #(
            .p_rise_scale (p_rise_scale),
            .p_fall_scale (p_fall_scale)
         ) u_ch (
            .i_clk   (i_clk),
            .i_rst_n (i_rst_n),
            .i_en    (i_en),
            .i_in    (in_s[k]),
            .o_out   (o_out[k]),
            .o_rise  (o_rise[k]),
            .o_fall  (o_fall[k]),
            .o_state (state_w[k])
         );
      end
   endgenerate

   // Busy whenever any channel is qualifying a transition.
   always_comb begin
      o_busy = 1'b0;
      for (int i = 0; i < p_channels; i++) begin
         if (state_w[i] == RISE || state_w[i] == FALL) o_busy = 1'b1;
      end
   end

endmodule

// File: tb/tb_schmitt_trigger_array.sv
// Directed bench: default array (rise=fall=5) and an asymmetric array
// (rise=1, fall=3), both 8 channels, sharing clock, reset and enable.
module tb_schmitt_trigger_array;

   logic       clk = 1'b0;
   logic       rst_n;
   logic       en;
   logic [7:0] in_a, in_b;
   logic [7:0] out_a, rise_a, fall_a;
   logic [7:0] out_b, rise_b, fall_b;
   logic       busy_a, busy_b;

   int n_checks = 0;
   int n_fail   = 0;

   // clock / reset block
   always #5 clk = ~clk;

   schmitt_trigger_array #(
      .p_channels(8), .p_rise_scale(5), .p_fall_scale(5)
   ) dut_a (
      .i_clk(clk), .i_rst_n(rst_n), .i_en(en), .i_in(in_a),
      .o_out(out_a), .o_rise(rise_a), .o_fall(fall_a), .o_busy(busy_a)
   );

   schmitt_trigger_array #(
      .p_channels(8), .p_rise_scale(1), .p_fall_scale(3)
   ) dut_b (
      .i_clk(clk), .i_rst_n(rst_n), .i_en(en), .i_in(in_b),
      .o_out(out_b), .o_rise(rise_b), .o_fall(fall_b), .o_busy(busy_b)
   );

   // one active edge, then settle away from it
   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic check(input string tag, input logic [7:0] obs, input logic [7:0] exp);
      n_checks++;
      assert (obs === exp) else begin
         n_fail++;
         $error("FAIL %s: observed %h expected %h", tag, obs, exp);
      end
   endtask

   task automatic check_a(input string tag, input logic [7:0] o, input logic [7:0] r,
                          input logic [7:0] f, input logic b);
      check({tag, ".out"},  out_a, o);
      check({tag, ".rise"}, rise_a, r);
      check({tag, ".fall"}, fall_a, f);
      check({tag, ".busy"}, {7'd0, busy_a}, {7'd0, b});
   endtask

   task automatic check_b(input string tag, input logic [7:0] o, input logic [7:0] r,
                          input logic [7:0] f, input logic b);
      check({tag, ".out"},  out_b, o);
      check({tag, ".rise"}, rise_b, r);
      check({tag, ".fall"}, fall_b, f);
      check({tag, ".busy"}, {7'd0, busy_b}, {7'd0, b});
   endtask

   initial begin
      // reset state
      rst_n = 1'b0;
      en    = 1'b1;
      in_a  = 8'h0F;
      in_b  = 8'h00;
      #12;
      check_a("rst_a", 8'h00, 8'h00, 8'h00, 1'b0);
      check_b("rst_b", 8'h00, 8'h00, 8'h00, 1'b0);
      rst_n = 1'b1;

      // first enabled edge fixes the initial level, no events
      tick();
      check_a("start_a", 8'h0F, 8'h00, 8'h00, 1'b0);
      check_b("start_b", 8'h00, 8'h00, 8'h00, 1'b0);

      // ch4 held high: switches on the 5th sampling edge
      in_a = 8'h1F;
      for (int i = 1; i <= 4; i++) begin
         tick();
         check_a($sformatf("rise_wait%0d", i), 8'h0F, 8'h00, 8'h00, 1'b1);
      end
      tick();
      check_a("rise_sw", 8'h1F, 8'h10, 8'h00, 1'b0);
      tick();
      check_a("rise_after", 8'h1F, 8'h00, 8'h00, 1'b0);

      // ch1 3-cycle low glitch is rejected
      in_a = 8'h1D;
      for (int i = 1; i <= 3; i++) begin
         tick();
         check_a($sformatf("glitch%0d", i), 8'h1F, 8'h00, 8'h00, 1'b1);
      end
      in_a = 8'h1F;
      tick();
      check_a("glitch_end", 8'h1F, 8'h00, 8'h00, 1'b0);
      tick();
      check_a("glitch_hold", 8'h1F, 8'h00, 8'h00, 1'b0);

      // asymmetric array: single-cycle high on ch2 rises at once, falls 3 later
      in_b = 8'h04;
      tick();
      check_b("b_rise", 8'h04, 8'h04, 8'h00, 1'b0);
      in_b = 8'h00;
      tick();
      check_b("b_fall1", 8'h04, 8'h00, 8'h00, 1'b1);
      tick();
      check_b("b_fall2", 8'h04, 8'h00, 8'h00, 1'b1);
      tick();
      check_b("b_fall3", 8'h00, 8'h00, 8'h04, 1'b0);
      tick();
      check_b("b_idle", 8'h00, 8'h00, 8'h00, 1'b0);

      // enable freeze mid-RISE on ch5 at count 2
      in_a = 8'h3F;
      tick();
      tick();
      check_a("en_pre", 8'h1F, 8'h00, 8'h00, 1'b1);
      en = 1'b0;
      for (int i = 1; i <= 10; i++) begin
         tick();
         check_a($sformatf("en_frz%0d", i), 8'h1F, 8'h00, 8'h00, 1'b1);
      end
      en = 1'b1;
      tick();
      check_a("en_res1", 8'h1F, 8'h00, 8'h00, 1'b1);
      tick();
      check_a("en_res2", 8'h1F, 8'h00, 8'h00, 1'b1);
      tick();
      check_a("en_res3", 8'h3F, 8'h20, 8'h00, 1'b0);

      // async reset mid-FALL on ch0
      in_a = 8'h3E;
      tick();
      tick();
      check_a("fall_mid", 8'h3F, 8'h00, 8'h00, 1'b1);
      #2;
      rst_n = 1'b0;
      #1;
      check_a("arst_a", 8'h00, 8'h00, 8'h00, 1'b0);
      check_b("arst_b", 8'h00, 8'h00, 8'h00, 1'b0);
      #1;
      rst_n = 1'b1;
      tick();
      check_a("arst_rel", 8'h3E, 8'h00, 8'h00, 1'b0);
      check_b("arst_rel_b", 8'h00, 8'h00, 8'h00, 1'b0);
      tick();
      check_a("arst_idle", 8'h3E, 8'h00, 8'h00, 1'b0);

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
